// File: rtl/logic_arb_pkg.sv
// Shared definitions for the logic-unit arbiter: operand width, FSM states
// and a one-hot to index helper.
package logic_arb_pkg;
  localparam int LU_W = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Supports up to 8 requesters; callers zero-pad narrower vectors.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = r | 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/unit/response bundle between requesters, the arbiter and the shared unit.
interface logic_unit_arbiter_if #(parameter int NREQ = 4, parameter int IDW = 3);
  import logic_arb_pkg::*;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [LU_W*NREQ-1:0] req_a, req_b, req_c;
  logic [LU_W-1:0]      unit_a, unit_b, unit_c, unit_y;
  logic                 rsp_valid, rsp_ready;
  logic [LU_W-1:0]      rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, req_c, unit_y, rsp_ready,
    output req_ready, unit_a, unit_b, unit_c, rsp_valid, rsp_data, rsp_id, busy
  );
  modport master (
    output req_valid, req_a, req_b, req_c, unit_y, rsp_ready,
    input  req_ready, unit_a, unit_b, unit_c, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/logic_arb_pick.sv
// Winner selection. LOGIC_ARB_RR_EN: round-robin from ptr; otherwise fixed
// priority (lowest index) with no pointer input.
module logic_arb_pick
  import logic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_valid,
`ifdef LOGIC_ARB_RR_EN
  input  logic [IDW-1:0]  ptr,
`endif
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  idx
);
  logic [NREQ-1:0] sel;

`ifdef LOGIC_ARB_RR_EN
  logic [NREQ-1:0] mask, hi;
  // Prefer requests at or above ptr; fall back to the full set to wrap.
  always_comb begin
    mask = ~((NREQ'(1) << ptr) - NREQ'(1));
    hi   = req_valid & mask;
    sel  = (|hi) ? hi : req_valid;
  end
`else
  assign sel = req_valid;
`endif

  assign win = sel & (~sel + NREQ'(1));
  assign idx = IDW'(oh2idx(8'(win)));
endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one combinational logic unit among NREQ requesters with a single
// registered valid/ready response. Policy selected by LOGIC_ARB_RR_EN.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input logic clk,
  input logic rst_n,
  logic_unit_arbiter_if.slave bus
);
  state_t          state;
  logic            can_issue, grant;
  logic [NREQ-1:0] win;
  logic [IDW-1:0]  widx;
  logic [LU_W-1:0] mux_a, mux_b, mux_c;

`ifdef LOGIC_ARB_RR_EN
  logic [IDW-1:0] ptr;
  logic_arb_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid(bus.req_valid), .ptr(ptr), .win(win), .idx(widx)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     ptr <= '0;
    else if (grant) ptr <= (widx == IDW'(NREQ-1)) ? '0 : widx + IDW'(1);
`else
  logic_arb_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid(bus.req_valid), .win(win), .idx(widx)
  );
`endif

  // rst_n gates the grant so req_ready/unit_* fall immediately in reset.
  assign can_issue = (state == EMPTY) || bus.rsp_ready;
  assign grant     = rst_n && can_issue && (|bus.req_valid);
  assign bus.req_ready = grant ? win : '0;

  always_comb begin
    mux_a = '0;
    mux_b = '0;
    mux_c = '0;
    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready[i]) begin
        mux_a = mux_a | bus.req_a[LU_W*i +: LU_W];
        mux_b = mux_b | bus.req_b[LU_W*i +: LU_W];
        mux_c = mux_c | bus.req_c[LU_W*i +: LU_W];
      end
  end

  assign bus.unit_a = mux_a;
  assign bus.unit_b = mux_b;
  assign bus.unit_c = mux_c;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= EMPTY;
      bus.rsp_data <= '0;
      bus.rsp_id   <= '0;
    end else if (grant) begin
      state        <= FULL;
      bus.rsp_data <= bus.unit_y;
      bus.rsp_id   <= widx;
    end else if (bus.rsp_ready) begin
      state        <= EMPTY;
    end

  assign bus.rsp_valid = (state == FULL);
  assign bus.busy      = (state == FULL) || (|bus.req_valid);
endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 3;
`ifdef LOGIC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic_unit_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  logic_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  assign bus.unit_y = bus.unit_a | (bus.unit_b & ~bus.unit_c);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  logic [3:0] exp_rr;

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_c = '0;
    bus.rsp_ready = 1'b0;
    #12;
    chk("rst_valid", bus.rsp_valid === 1'b0, bus.rsp_valid, 1'b0);
    chk("rst_data",  bus.rsp_data === 4'h0, bus.rsp_data, 4'h0);
    chk("rst_id",    bus.rsp_id === 3'd0, bus.rsp_id, 3'd0);
    chk("rst_ready", bus.req_ready === 4'b0000, bus.req_ready, 4'b0000);
    chk("rst_busy",  bus.busy === 1'b0, bus.busy, 1'b0);
    rst_n = 1'b1;
    step();

    bus.req_valid = 4'b0001;
    bus.req_a[3:0] = 4'b1010; bus.req_b[3:0] = 4'b0101; bus.req_c[3:0] = 4'b1100;
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_ready", bus.req_ready === 4'b0001, bus.req_ready, 4'b0001);
    chk("single_unit_a", bus.unit_a === 4'b1010, bus.unit_a, 4'b1010);
    chk("single_busy", bus.busy === 1'b1, bus.busy, 1'b1);
    step();
    bus.req_valid = '0;
    chk("single_rsp_valid", bus.rsp_valid === 1'b1, bus.rsp_valid, 1'b1);
    chk("single_rsp_data", bus.rsp_data === 4'b1011, bus.rsp_data, 4'b1011);
    chk("single_rsp_id", bus.rsp_id === 3'd0, bus.rsp_id, 3'd0);
    #1;
    chk("idle_unit_a", bus.unit_a === 4'b0000, bus.unit_a, 4'b0000);
    step();
    chk("drain_valid", bus.rsp_valid === 1'b0, bus.rsp_valid, 1'b0);

    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_a[7:4] = 4'b1010; bus.req_b[7:4] = 4'b0000; bus.req_c[7:4] = 4'b0000;
    step();
    bus.req_valid = '0;
    chk("pre_rst_valid", bus.rsp_valid === 1'b1, bus.rsp_valid, 1'b1);
    chk("pre_rst_data", bus.rsp_data === 4'b1010, bus.rsp_data, 4'b1010);
    chk("pre_rst_id", bus.rsp_id === 3'd1, bus.rsp_id, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.rsp_valid === 1'b0, bus.rsp_valid, 1'b0);
    chk("mid_rst_data", bus.rsp_data === 4'h0, bus.rsp_data, 4'h0);
    chk("mid_rst_id", bus.rsp_id === 3'd0, bus.rsp_id, 3'd0);
    #2 rst_n = 1'b1;
    step();

    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[4*i +: 4] = 4'(i + 4);
      bus.req_b[4*i +: 4] = 4'b1001;
      bus.req_c[4*i +: 4] = 4'b0001;
    end
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = RR ? (k % 4) : 0;
      #1;
      chk("all_ready", bus.req_ready === 4'(1 << w), bus.req_ready, 4'(1 << w));
      step();
      chk("all_rsp_valid", bus.rsp_valid === 1'b1, bus.rsp_valid, 1'b1);
      chk("all_rsp_id", bus.rsp_id === 3'(w), bus.rsp_id, 3'(w));
      chk("all_rsp_data", bus.rsp_data === 4'(w + 12), bus.rsp_data, 4'(w + 12));
    end
    bus.req_valid = '0;
    step();
    chk("all_drain", bus.rsp_valid === 1'b0, bus.rsp_valid, 1'b0);

    bus.req_valid = 4'b0011;
    #1;
    chk("bp_first_ready", bus.req_ready === (RR ? 4'b0010 : 4'b0001), bus.req_ready, RR ? 4'b0010 : 4'b0001);
    step();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_zero", bus.req_ready === 4'b0000, bus.req_ready, 4'b0000);
      chk("bp_valid_held", bus.rsp_valid === 1'b1, bus.rsp_valid, 1'b1);
      chk("bp_id_held", bus.rsp_id === (RR ? 3'd1 : 3'd0), bus.rsp_id, RR ? 3'd1 : 3'd0);
      chk("bp_data_held", bus.rsp_data === (RR ? 4'd13 : 4'd12), bus.rsp_data, RR ? 4'd13 : 4'd12);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.req_ready === 4'b0001, bus.req_ready, 4'b0001);
    step();
    chk("bp_release_id", bus.rsp_id === 3'd0, bus.rsp_id, 3'd0);
    chk("bp_release_data", bus.rsp_data === 4'd12, bus.rsp_data, 4'd12);

    bus.req_valid = 4'b0100;
    #1;
    chk("r2_ready_a", bus.req_ready === 4'b0100, bus.req_ready, 4'b0100);
    step();
    #1;
    chk("r2_ready_wrap", bus.req_ready === 4'b0100, bus.req_ready, 4'b0100);
    step();
    chk("r2_rsp_id", bus.rsp_id === 3'd2, bus.rsp_id, 3'd2);
    chk("r2_rsp_data", bus.rsp_data === 4'd14, bus.rsp_data, 4'd14);
    bus.req_valid = 4'b1001;
    #1;
    exp_rr = RR ? 4'b1000 : 4'b0001;
    chk("ptr_after_wrap", bus.req_ready === exp_rr, bus.req_ready, exp_rr);
    step();
    chk("ptr_rsp_id", bus.rsp_id === (RR ? 3'd3 : 3'd0), bus.rsp_id, RR ? 3'd3 : 3'd0);
    bus.req_valid = '0;
    step();
    chk("final_busy", bus.busy === 1'b0, bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end
endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one combinational 4-bit, three-operand logic unit (a/b/c in, y out) among NREQ requesters. Each cycle it grants at most one valid request, drives that request's operands onto the unit, and registers the unit's result with the requester's ID. Results leave through a single valid/ready response port, and a stalled response blocks new grants. The block sits between the lab-level requesters and the shared logic unit instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, 3: ID width; must satisfy 2^IDW ≥ NREQ.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_a, req_b, req_c  in  4*NREQ each  packed operands; requester i uses bits [4i+3:4i].
- req_ready  out  NREQ  one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high.
- unit_a, unit_b, unit_c  out  4 each  operands to the shared logic unit.
- unit_y  in  4  combinational result from the unit.
- rsp_valid  out  1  response register holds data.
- rsp_ready  in  1  downstream accepts the response.
- rsp_data  out  4  captured unit_y.
- rsp_id  out  IDW  index of the granted requester.
- busy  out  1  high when rsp_valid is high or any req_valid bit is high.

## Operation
- The block has two states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- can_issue = (state == EMPTY) or rsp_ready.
- A grant happens when can_issue is true and at least one req_valid bit is set. The winner comes from the pick policy (see Configuration).
- req_ready is combinational and equals the one-hot winner when a grant happens; otherwise it is all zeros. req_ready[i] is never asserted without req_valid[i].
- unit_a/b/c are combinational muxes of the winner's operands. With no grant they drive 4'b0000.
- On a grant, the next clock edge loads rsp_data ← unit_y, loads rsp_id ← winner, and sets the state to FULL.
- FULL with rsp_ready and no grant: the state goes to EMPTY. FULL with rsp_ready and a grant: the register reloads and stays FULL, giving back-to-back throughput.
- FULL without rsp_ready: rsp_data and rsp_id hold, and no requester is granted.
- Requesters must hold valid and operands stable until accepted. The arbiter does not check this.
- Reset (asynchronous, any cycle): state EMPTY, rsp_valid 0, rsp_data 0, rsp_id 0, rotation pointer 0. req_ready and unit_* go to zero combinationally. A response pending at reset is discarded.

## Timing
- Latency: a request granted in cycle N produces rsp_valid in cycle N+1.
- Throughput: one result per cycle while rsp_ready stays high.
- The combinational path req_valid → req_ready and operands → unit_* → unit_y ends at the rsp_data flop. There is no combinational path from rsp_ready to rsp_data.
- Simultaneous events:
  - A response handshake and a new grant in the same cycle are legal; the new data replaces the old.
  - Reset deassertion is synchronised externally; the block assumes a clean release.

## Configuration
- LOGIC_ARB_RR_EN defined:
  - Round-robin policy.
  - The search starts at the rotation pointer p and takes the first valid index in the order p, p+1, …, NREQ-1, 0, …
  - After a grant to i, p ← (i+1) mod NREQ.
  - p holds when there is no grant.
- LOGIC_ARB_RR_EN undefined:
  - Fixed priority; the lowest valid index wins.
  - No pointer register is built.

## Structure
- The shared package logic_arb_pkg holds:
  - LU_W = 4 (operand width).
  - The state enum {EMPTY, FULL}.
  - A helper for onehot-to-index.
- Sub-module logic_arb_pick:
  - Inputs: req_valid and the pointer.
  - Outputs: one-hot winner and index.
  - It contains both policies under LOGIC_ARB_RR_EN.
- The top level holds the FSM, the operand mux, and the response register.

## Test plan
- Reset mid-response: rsp_valid = 1, rsp_data = 4'b1010, then rst_n pulses low → rsp_valid, rsp_data and rsp_id are 0 immediately, before the next clock.
- Single requester: req_valid = 0001, a = 1010, b = 0101, c = 1100, unit model y = 1011, rsp_ready = 1 → req_ready = 0001 in cycle 0; cycle 1 shows rsp_valid = 1, rsp_data = 1011, rsp_id = 0.
- All four requesters held valid with rsp_ready = 1, RR enabled → grants in order 0,1,2,3,0; rsp_id follows one cycle later; no idle cycles.
- Same stimulus with the macro undefined → every grant goes to requester 0; rsp_id stays 0.
- Backpressure: rsp_ready = 0 for 3 cycles after the first response → req_ready = 0000 and rsp_data/rsp_id held. When rsp_ready rises, the next grant and handshake happen in the same cycle.
- Requester 2 only, RR pointer at 3 → search wraps and grants 2; the pointer becomes 3.
